execute_stage: RTL

//  Consumer end of the ID/EX pipeline interface: takes registered decode outputs (ALU_CONTROL, ALU_SRC2, D1, D2, Imm, PC, RS1/RS2, control bits),

---
 rtl/execute_stage_pkg.sv | 31 +++
 rtl/execute_stage_if.sv | 30 +++
 rtl/execute_stage_alu.sv | 19 +
 rtl/execute_stage.sv | 36 +++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared widths, ALU/operand-select codes and immediate/forwarding helpers
package execute_stage_pkg;
  localparam int XLEN = 32;
  localparam int RADDR = 5;
  localparam int IMMW = 25;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT
  } alu_op_e;
  typedef enum logic [1:0] {SRC2_REG, SRC2_I, SRC2_S, SRC2_U} alu_src2_e;
  // imm carries instr[31:7], so instr[n] is imm[n-7]
  function automatic logic [XLEN-1:0] imm_i(input logic [IMMW-1:0] i);
    return {{20{i[24]}}, i[24:13]};
  endfunction
  function automatic logic [XLEN-1:0] imm_s(input logic [IMMW-1:0] i);
    return {{20{i[24]}}, i[24:18], i[4:0]};
  endfunction
  function automatic logic [XLEN-1:0] imm_b(input logic [IMMW-1:0] i);
    return {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
  endfunction
  function automatic logic [XLEN-1:0] imm_u(input logic [IMMW-1:0] i);
    return {i[24:5], 12'b0};
  endfunction
  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded
  function automatic logic [XLEN-1:0] fwd(
    input logic [RADDR-1:0] rs, input logic [XLEN-1:0] d,
    input logic we_m, input logic [RADDR-1:0] a_m, input logic [XLEN-1:0] d_m,
    input logic we_w, input logic [RADDR-1:0] a_w, input logic [XLEN-1:0] d_w);
    return (we_m && a_m != '0 && a_m == rs) ? d_m :
           (we_w && a_w != '0 && a_w == rs) ? d_w : d;
  endfunction
endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: ID/EX inputs, MEM/WB forwarding taps and EX/MEM outputs of the execute stage
interface execute_stage_if;
  import execute_stage_pkg::*;
  logic en, flush;
  logic [2:0] alu_control;
  logic [1:0] alu_src2;
  logic brn_cond, mem_we, de_we, mem_reg;
  logic [XLEN-1:0] d1, d2, pc_ex;
  logic [IMMW-1:0] imm;
  logic [RADDR-1:0] rs1_ex, rs2_ex;
  logic fwd_we_m, fwd_we_w;
  logic [RADDR-1:0] fwd_a_m, fwd_a_w;
  logic [XLEN-1:0] fwd_d_m, fwd_d_w;
  logic brn_taken;
  logic [XLEN-1:0] brn_target, alu_res_m, wd_m;
  logic [RADDR-1:0] rd_m;
  logic mem_we_m, de_we_m, mem_reg_m;
  modport master (
    output en, flush, alu_control, alu_src2, brn_cond, mem_we, de_we, mem_reg,
    output d1, d2, pc_ex, imm, rs1_ex, rs2_ex,
    output fwd_we_m, fwd_a_m, fwd_d_m, fwd_we_w, fwd_a_w, fwd_d_w,
    input brn_taken, brn_target, alu_res_m, wd_m, rd_m, mem_we_m, de_we_m, mem_reg_m
  );
  modport slave (
    input en, flush, alu_control, alu_src2, brn_cond, mem_we, de_we, mem_reg,
    input d1, d2, pc_ex, imm, rs1_ex, rs2_ex,
    input fwd_we_m, fwd_a_m, fwd_d_m, fwd_we_w, fwd_a_w, fwd_d_w,
    output brn_taken, brn_target, alu_res_m, wd_m, rd_m, mem_we_m, de_we_m, mem_reg_m
  );
endinterface

// File: rtl/execute_stage_alu.sv
// execute_stage_alu: combinational RV32 integer ALU
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res
);
  always_comb
    res = op == ALU_ADD ? a + b :
          op == ALU_SUB ? a - b :
          op == ALU_AND ? a & b :
          op == ALU_OR  ? a | b :
          op == ALU_XOR ? a ^ b :
          op == ALU_SLL ? a << b[4:0] :
          op == ALU_SRL ? a >> b[4:0] :
                          {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, BEQ resolution and the EX/MEM pipeline register
module execute_stage
  import execute_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  execute_stage_if.slave io
);
  logic [XLEN-1:0] op1, rs2f, op2, res;
  always_comb begin
    op1  = fwd(io.rs1_ex, io.d1, io.fwd_we_m, io.fwd_a_m, io.fwd_d_m, io.fwd_we_w, io.fwd_a_w, io.fwd_d_w);
    rs2f = fwd(io.rs2_ex, io.d2, io.fwd_we_m, io.fwd_a_m, io.fwd_d_m, io.fwd_we_w, io.fwd_a_w, io.fwd_d_w);
    op2  = io.alu_src2 == SRC2_REG ? rs2f :
           io.alu_src2 == SRC2_I   ? imm_i(io.imm) :
           io.alu_src2 == SRC2_S   ? imm_s(io.imm) : imm_u(io.imm);
  end
  execute_stage_alu u_alu (.op(alu_op_e'(io.alu_control)), .a(op1), .b(op2), .res(res));
  assign io.brn_taken  = io.brn_cond && (op1 == rs2f);
  assign io.brn_target = io.pc_ex + imm_b(io.imm);
  always_ff @(posedge clk or negedge rst)
    if (!rst || io.flush) begin
      io.alu_res_m <= '0;
      io.wd_m      <= '0;
      io.rd_m      <= '0;
      io.mem_we_m  <= 1'b0;
      io.de_we_m   <= 1'b0;
      io.mem_reg_m <= 1'b0;
    end else if (io.en) begin
      io.alu_res_m <= res;
      io.wd_m      <= rs2f;
      io.rd_m      <= io.imm[4:0];
      io.mem_we_m  <= io.mem_we;
      io.de_we_m   <= io.de_we;
      io.mem_reg_m <= io.mem_reg;
    end
endmodule
